multi_clk_divider: RTL and testbench

- Parametrised successor to the fixed single-output clock divider.
- Provides N independent divider channels, each with a runtime-programmable divisor, enable, and continuous or one-shot mode.
- Each channel produces a 50%-duty wave and a single-cycle tick strobe.
- Sits between FPGA_clk and the queue-display, timer and debounce logic, replacing the per-use fixed dividers.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 114 +++++++++++
 rtl/multi_clk_divider.sv | 62 ++++++
 tb/tb_multi_clk_divider.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared mode encoding, channel-select width helper and default divisor for the clock divider.
// Pure declarations: no latency, no flow control.
package clk_div_pkg;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  // 50 MHz / (2 * (24_999_999 + 1)) = 1 Hz wave
  localparam int unsigned DEFAULT_DIV_1HZ = 24_999_999;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow divisor, mode/enable, registered wave and tick.
// Tick one cycle after terminal count; no backpressure, config writes always accepted.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               DIV_W       = 25,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_1HZ),
  parameter logic             DEFAULT_EN  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sync_clr_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_mode_i,
  input  logic             cfg_en_i,
  output logic             wave_o,
  output logic             tick_o,
  output logic             pend_o,
  output logic             en_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  mode_e            mode_q, mode_d;
  logic             en_q, en_d;
  logic             wave_q, wave_d;
  logic             tick_q, tick_d;
  logic             terminal;

  assign terminal = (cnt_q == div_q);

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    mode_d   = mode_q;
    en_d     = en_q;
    wave_d   = wave_q;
    tick_d   = 1'b0;

    if (!en_q) begin
      cnt_d  = '0;
      wave_d = 1'b0;
      pend_d = 1'b0;
    end else if (!sync_clr_i) begin
      if (terminal) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
        if (mode_q == MODE_ONESHOT) en_d = 1'b0;
        else                        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (sync_clr_i) begin
      cnt_d  = '0;
      wave_d = 1'b0;
      tick_d = 1'b0;
    end

    // A running channel takes the new divisor only at its next terminal count
    if (wr_i) begin
      mode_d = mode_e'(cfg_mode_i);
      if (!en_q || !cfg_en_i) begin
        div_d  = cfg_div_i;
        en_d   = cfg_en_i;
        cnt_d  = '0;
        wave_d = 1'b0;
        tick_d = 1'b0;
        pend_d = 1'b0;
      end else begin
        shadow_d = cfg_div_i;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      div_q    <= DEFAULT_DIV;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      mode_q   <= MODE_CONT;
      en_q     <= DEFAULT_EN;
      wave_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      en_q     <= en_d;
      wave_q   <= wave_d;
      tick_q   <= tick_d;
    end
  end

  assign wave_o = wave_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;
  assign en_o   = en_q;

endmodule

// File: rtl/multi_clk_divider.sv
// N independent programmable clock-divider channels with write decode and bad-channel error pulse.
// All outputs registered (cfg_err one cycle after the write); no backpressure.
module multi_clk_divider
  import clk_div_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              DIV_W       = 25,
  parameter int unsigned     DEFAULT_DIV = DEFAULT_DIV_1HZ,
  parameter logic [N_CH-1:0] DEFAULT_EN  = {N_CH{1'b1}}
) (
  input  logic                    FPGA_clk,
  input  logic                    reset_n,
  input  logic                    sync_clr,
  input  logic                    cfg_we,
  input  logic [ch_w(N_CH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic                    cfg_mode,
  input  logic                    cfg_en,
  output logic                    cfg_err,
  output logic [N_CH-1:0]         wave,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         pend,
  output logic [N_CH-1:0]         en_st
);

  logic ch_valid;
  logic cfg_err_q, cfg_err_d;

  assign ch_valid  = (int'(cfg_ch) < N_CH);
  assign cfg_err_d = cfg_we && !ch_valid;

  always_ff @(posedge FPGA_clk or negedge reset_n) begin
    if (!reset_n) cfg_err_q <= 1'b0;
    else          cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && ch_valid && (int'(cfg_ch) == i);

    clk_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DIV_W'(DEFAULT_DIV)),
      .DEFAULT_EN (DEFAULT_EN[i])
    ) u_chan (
      .clk_i     (FPGA_clk),
      .rst_ni    (reset_n),
      .sync_clr_i(sync_clr),
      .wr_i      (wr),
      .cfg_div_i (cfg_div),
      .cfg_mode_i(cfg_mode),
      .cfg_en_i  (cfg_en),
      .wave_o    (wave[i]),
      .tick_o    (tick[i]),
      .pend_o    (pend[i]),
      .en_o      (en_st[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider: N_CH=4, DIV_W=8, DEFAULT_DIV=3, plus an N_CH=3 copy
// whose 2-bit channel select can name a channel that does not exist.
module tb_multi_clk_divider;

  logic       clk;
  logic       reset_n;
  logic       sync_clr;
  logic       cfg_we;
  logic       cfg_we3;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic       cfg_en;
  logic       cfg_err;
  logic [3:0] wave, tick, pend, en_st;
  logic       cfg_err3;
  logic [2:0] wave3, tick3, pend3, en_st3;

  int tests_run = 0;
  int tests_failed = 0;

  multi_clk_divider #(.N_CH(4), .DIV_W(8), .DEFAULT_DIV(3)) u_dut (
    .FPGA_clk(clk), .reset_n(reset_n), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
    .cfg_err(cfg_err), .wave(wave), .tick(tick), .pend(pend), .en_st(en_st)
  );

  multi_clk_divider #(.N_CH(3), .DIV_W(8), .DEFAULT_DIV(3)) u_dut3 (
    .FPGA_clk(clk), .reset_n(reset_n), .sync_clr(sync_clr), .cfg_we(cfg_we3),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
    .cfg_err(cfg_err3), .wave(wave3), .tick(tick3), .pend(pend3), .en_st(en_st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at a negedge with reset just released: every counter is 0.
  task automatic do_reset();
    reset_n  = 1'b0;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_we3  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge right after the write edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] d, input logic m, input logic e);
    cfg_ch   = ch;
    cfg_div  = d;
    cfg_mode = m;
    cfg_en   = e;
    cfg_we   = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_t, exp_w;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({wave, tick, pend, cfg_err} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wave=%b tick=%b pend=%b err=%b want zeros", wave, tick, pend, cfg_err);
    end
    tests_run++;
    if (en_st !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_en: got %b want 1111", en_st);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_t = (k % 4 == 0) ? 4'hF : 4'h0;
      exp_w = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
      tests_run++;
      if (tick !== exp_t || wave !== exp_w) begin
        tests_failed++;
        $display("FAIL default_run k=%0d: got tick=%b wave=%b want tick=%b wave=%b", k, tick, wave, exp_t, exp_w);
      end
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (wave !== 4'h0 || tick !== 4'h0 || pend !== 4'h0 || en_st !== 4'hF) begin
      tests_failed++;
      $display("FAIL async_reset: got wave=%b tick=%b pend=%b en=%b want 0000 0000 0000 1111", wave, tick, pend, en_st);
    end
  endtask

  task automatic test_min_div();
    logic exp_w;
    do_reset();
    cfg_write(2'd1, 8'd0, 1'b0, 1'b0);
    tests_run++;
    if (en_st[1] !== 1'b0 || wave[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ch1_disable: got en=%b wave=%b want 0 0", en_st[1], wave[1]);
    end
    cfg_write(2'd1, 8'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_w = (k % 2 == 1);
      tests_run++;
      if (tick[1] !== 1'b1 || wave[1] !== exp_w) begin
        tests_failed++;
        $display("FAIL div0 k=%0d: got tick=%b wave=%b want tick=1 wave=%b", k, tick[1], wave[1], exp_w);
      end
    end
    cfg_write(2'd2, 8'd0, 1'b0, 1'b0);
    cfg_write(2'd2, 8'd255, 1'b0, 1'b1);
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      tests_run++;
      if (tick[2] !== (k % 256 == 0) || wave[2] !== (k >= 256 && k < 512)) begin
        tests_failed++;
        $display("FAIL div255 k=%0d: got tick=%b wave=%b want tick=%b wave=%b", k, tick[2], wave[2],
                 (k % 256 == 0), (k >= 256 && k < 512));
      end
    end
  endtask

  task automatic test_glitch_free();
    logic exp_t, exp_p, exp_w;
    do_reset();
    cfg_write(2'd0, 8'd5, 1'b0, 1'b0);
    cfg_write(2'd0, 8'd5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    cfg_write(2'd0, 8'd1, 1'b0, 1'b1);
    tests_run++;
    if (pend[0] !== 1'b1 || tick[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL shadow_pend: got pend=%b tick=%b want pend=1 tick=0", pend[0], tick[0]);
    end
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      exp_t = (j == 3 || j == 5 || j == 7 || j == 9);
      exp_p = (j < 3);
      exp_w = (j == 3 || j == 4 || j == 7 || j == 8);
      tests_run++;
      if (tick[0] !== exp_t || pend[0] !== exp_p || wave[0] !== exp_w) begin
        tests_failed++;
        $display("FAIL glitch_free j=%0d: got tick=%b pend=%b wave=%b want %b %b %b", j, tick[0], pend[0], wave[0],
                 exp_t, exp_p, exp_w);
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    cfg_write(2'd3, 8'd0, 1'b0, 1'b0);
    cfg_write(2'd3, 8'd9, 1'b1, 1'b1);
    tests_run++;
    if (en_st[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL oneshot_arm: got en=%b want 1", en_st[3]);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tests_run++;
      if (tick[3] !== (k == 10) || wave[3] !== 1'b0 || en_st[3] !== (k < 10)) begin
        tests_failed++;
        $display("FAIL oneshot k=%0d: got tick=%b wave=%b en=%b want %b 0 %b", k, tick[3], wave[3], en_st[3],
                 (k == 10), (k < 10));
      end
    end
  endtask

  task automatic test_invalid_ch();
    do_reset();
    tests_run++;
    if (cfg_err3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_idle: got %b want 0", cfg_err3);
    end
    cfg_ch  = 2'd3;
    cfg_div = 8'd7;
    cfg_en  = 1'b0;
    cfg_we3 = 1'b1;
    @(negedge clk);
    cfg_we3 = 1'b0;
    tests_run++;
    if (cfg_err3 !== 1'b1 || en_st3 !== 3'b111 || pend3 !== 3'b000) begin
      tests_failed++;
      $display("FAIL err_pulse: got err=%b en=%b pend=%b want 1 111 000", cfg_err3, en_st3, pend3);
    end
    @(negedge clk);
    tests_run++;
    if (cfg_err3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_one_cycle: got %b want 0", cfg_err3);
    end
    cfg_write(2'd3, 8'd3, 1'b0, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b0 || pend[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL valid_ch3: got err=%b pend=%b want 0 1", cfg_err, pend[3]);
    end
  endtask

  task automatic test_sync_clr();
    logic [3:0] exp_t, exp_w;
    do_reset();
    repeat (5) @(negedge clk);
    tests_run++;
    if (wave !== 4'hF) begin
      tests_failed++;
      $display("FAIL pre_clr_wave: got %b want 1111", wave);
    end
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    tests_run++;
    if (wave !== 4'h0 || tick !== 4'h0 || en_st !== 4'hF || pend !== 4'h0) begin
      tests_failed++;
      $display("FAIL sync_clr: got wave=%b tick=%b en=%b pend=%b want 0000 0000 1111 0000", wave, tick, en_st, pend);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_t = (k % 4 == 0) ? 4'hF : 4'h0;
      exp_w = (k >= 4 && k < 8) ? 4'hF : 4'h0;
      tests_run++;
      if (tick !== exp_t || wave !== exp_w) begin
        tests_failed++;
        $display("FAIL after_clr k=%0d: got tick=%b wave=%b want %b %b", k, tick, wave, exp_t, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_t;
    do_reset();
    repeat (3) @(negedge clk);
    cfg_write(2'd0, 8'd7, 1'b0, 1'b1);
    tests_run++;
    if (tick[0] !== 1'b1 || pend[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL collide_tick: got tick=%b pend=%b want 1 1", tick[0], pend[0]);
    end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      exp_t = (j == 4 || j == 12 || j == 20);
      tests_run++;
      if (tick[0] !== exp_t || pend[0] !== (j < 4)) begin
        tests_failed++;
        $display("FAIL collide j=%0d: got tick=%b pend=%b want %b %b", j, tick[0], pend[0], exp_t, (j < 4));
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_we3  = 1'b0;
    cfg_ch   = 2'd0;
    cfg_div  = 8'd0;
    cfg_mode = 1'b0;
    cfg_en   = 1'b0;
    test_reset();
    test_min_div();
    test_glitch_free();
    test_oneshot();
    test_invalid_ch();
    test_sync_clr();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
